// File: rtl/pte_walk_responder_pkg.sv
// Shared Sv32 PTE field layout and walk-responder state encoding.
// The MMU imports the same package, so keep the field positions in sync with it.
package pte_walk_responder_pkg;

  localparam int PTE_W = 32;

  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W_BIT = 2;
  localparam int PTE_X = 3;
  localparam int PTE_U = 4;
  localparam int PTE_G = 5;
  localparam int PTE_A = 6;
  localparam int PTE_D = 7;

  localparam logic [PTE_W-1:0] PTE_A_MASK = 32'h0000_0040;

  // Low flag byte of a PTE, MSB first, for code that prefers named fields.
  typedef struct packed {
    logic d;
    logic a;
    logic g;
    logic u;
    logic x;
    logic w;
    logic r;
    logic v;
  } pte_flags_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  function automatic logic [PTE_W-1:0] set_a_bit(input logic [PTE_W-1:0] pte);
    return pte | PTE_A_MASK;
  endfunction

endpackage

// File: rtl/pte_walk_responder_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins; on a tie the
// client that was not granted last wins. advance commits the current grant.
module rr_arb2
  import pte_walk_responder_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // Client that wins when both request; client 0 first out of reset.
  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase

    prio_d = prio_q;
    if (advance && (gnt != 2'b00)) begin
      prio_d = gnt[0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/pte_walk_responder.sv
// Memory-side responder for the I-side and D-side page-table walkers: one
// shared memory port, optional hardware A-bit update on valid leaf PTEs.
module pte_walk_responder
  import pte_walk_responder_pkg::*;
#(
  parameter bit SET_A = 1'b1
)
(
  input  logic        clk,
  input  logic        reset,

  input  logic        rd_req0,
  input  logic [31:0] pte_addr0,
  output logic        data_ready0,
  input  logic        rd_req1,
  input  logic [31:0] pte_addr1,
  output logic        data_ready1,
  output logic [31:0] pte_buf,

  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  input  logic        mem_err,

  output logic [1:0]  dbg_state
);

  // Handshake: rd_reqN is a level held by the MMU until data_readyN pulses;
  // mem_req is held with stable mem_we/mem_addr/mem_wdata until the cycle
  // mem_ack is sampled high, and mem_err only has meaning alongside mem_ack.

  logic [1:0]  state_q, state_d;
  logic        client_q, client_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] pte_buf_q, pte_buf_d;
  logic [1:0]  ready_q, ready_d;
  logic [1:0]  block_q, block_d;

  logic [1:0]  eligible;
  logic [1:0]  gnt;
  logic        arb_advance;
  logic [31:0] grant_addr;
  logic        needs_a;

  // block keeps a just-served request, still held by the MMU, from being
  // served a second time before the MMU has seen data_ready and dropped it.
  assign eligible    = {rd_req1, rd_req0} & ~block_q;
  assign arb_advance = (state_q == ST_IDLE);
  assign grant_addr  = gnt[1] ? pte_addr1 : pte_addr0;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (eligible),
    .advance (arb_advance),
    .gnt     (gnt)
  );

  // Only a valid leaf (R or X) with A clear gets written back.
  assign needs_a = SET_A & mem_rdata[PTE_V] & (mem_rdata[PTE_R] | mem_rdata[PTE_X])
                 & ~mem_rdata[PTE_A];

  always_comb begin
    state_d     = state_q;
    client_d    = client_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pte_buf_d   = pte_buf_q;
    ready_d     = 2'b00;
    block_d     = block_q & {rd_req1, rd_req0};

    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          client_d   = gnt[1];
          mem_addr_d = grant_addr & 32'hFFFF_FFFC;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          state_d    = ST_RD;
        end
      end

      ST_RD: begin
        if (mem_ack) begin
          if (mem_err) begin
            // A zero PTE has V=0, so the walker raises its own page fault.
            pte_buf_d         = '0;
            mem_req_d         = 1'b0;
            ready_d[client_q] = 1'b1;
            state_d           = ST_RESP;
          end else if (needs_a) begin
            mem_wdata_d = set_a_bit(mem_rdata);
            mem_we_d    = 1'b1;
            state_d     = ST_WR;
          end else begin
            pte_buf_d         = mem_rdata;
            mem_req_d         = 1'b0;
            ready_d[client_q] = 1'b1;
            state_d           = ST_RESP;
          end
        end
      end

      ST_WR: begin
        if (mem_ack) begin
          // The updated PTE is returned even if the write-back errors.
          pte_buf_d         = mem_wdata_q;
          mem_req_d         = 1'b0;
          mem_we_d          = 1'b0;
          ready_d[client_q] = 1'b1;
          state_d           = ST_RESP;
        end
      end

      ST_RESP: begin
        block_d[client_q] = 1'b1;
        state_d           = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      client_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      pte_buf_q   <= '0;
      ready_q     <= 2'b00;
      block_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      client_q    <= client_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      pte_buf_q   <= pte_buf_d;
      ready_q     <= ready_d;
      block_q     <= block_d;
    end
  end

  assign data_ready0 = ready_q[0];
  assign data_ready1 = ready_q[1];
  assign pte_buf     = pte_buf_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_pte_walk_responder.sv
// Bench for pte_walk_responder: a pure-read instance (index 0) and an A-bit
// updating instance (index 1) receive identical walker traffic.
module tb_pte_walk_responder;
  import pte_walk_responder_pkg::*;

  typedef struct {
    bit          act;
    logic [31:0] pte;
    bit          er;
    bit          ew;
    int          dly;
    int          k;
    logic [1:0]  lo;
  } txn_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT signals, one slot per instance ----------------
  logic        rd_req0 [2];
  logic [31:0] pte_addr0 [2];
  logic        data_ready0 [2];
  logic        rd_req1 [2];
  logic [31:0] pte_addr1 [2];
  logic        data_ready1 [2];
  logic [31:0] pte_buf [2];
  logic        mem_req [2];
  logic        mem_we [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        mem_ack [2];
  logic        mem_err [2];
  logic [1:0]  dbg_state [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pte_walk_responder #(.SET_A(g == 1)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .rd_req0     (rd_req0[g]),
      .pte_addr0   (pte_addr0[g]),
      .data_ready0 (data_ready0[g]),
      .rd_req1     (rd_req1[g]),
      .pte_addr1   (pte_addr1[g]),
      .data_ready1 (data_ready1[g]),
      .pte_buf     (pte_buf[g]),
      .mem_req     (mem_req[g]),
      .mem_we      (mem_we[g]),
      .mem_addr    (mem_addr[g]),
      .mem_wdata   (mem_wdata[g]),
      .mem_rdata   (mem_rdata[g]),
      .mem_ack     (mem_ack[g]),
      .mem_err     (mem_err[g]),
      .dbg_state   (dbg_state[g])
    );
  end

  // ---------------- bench state ----------------
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_q [4][$];       // index = dut*2 + client
  int          order_q [2][$];     // expected service order per dut
  int          last_served = 1;    // model of the tie-break history
  logic [31:0] mem_arr [2][2][8];  // per dut, per client region, 8 PTEs
  bit          err_rd [2][2];
  bit          err_wr [2][2];
  logic [31:0] exp_addr [2][2];
  bit          in_acc [2];
  int          lat [2];
  bit          hold_mem = 1'b0;
  bit          stray_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic bit leaf_without_a(input logic [31:0] p);
    return ((p & 32'h1) != 0) && ((p & 32'ha) != 0) && ((p & 32'h40) == 0);
  endfunction

  function automatic logic [31:0] model_pte(input bit set_a, input logic [31:0] p, input bit er);
    if (er) return 32'h0;
    if (set_a && leaf_without_a(p)) return p + 32'h40;
    return p;
  endfunction

  // ---------------- memory responder ----------------
  task automatic mem_complete(input int d);
    int c;
    int k;
    bit needed;
    c = int'(mem_addr[d][13]);
    k = int'(mem_addr[d][4:2]);
    check("mem_addr", mem_addr[d], exp_addr[d][c]);
    if (!mem_we[d]) begin
      mem_rdata[d] = mem_arr[d][c][k];
      mem_err[d]   = err_rd[d][c];
    end else begin
      needed = (d == 1) && leaf_without_a(mem_arr[d][c][k]);
      check("write_needed", 32'(needed), 32'd1);
      check("mem_wdata", mem_wdata[d], mem_arr[d][c][k] | 32'h40);
      if (!err_wr[d][c]) mem_arr[d][c][k] = mem_wdata[d];
      mem_err[d] = err_wr[d][c];
    end
    mem_ack[d] = 1'b1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      mem_ack[d] = 1'b0;
      mem_err[d] = 1'b0;
      mem_rdata[d] = 32'h0;
      in_acc[d] = 1'b0;
      lat[d] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        mem_ack[d] = 1'b0;
        mem_err[d] = 1'b0;
        if (stray_ack) begin
          mem_ack[d] = 1'b1;
        end else if (!mem_req[d] || reset) begin
          in_acc[d] = 1'b0;
        end else if (!hold_mem) begin
          if (!in_acc[d]) begin
            in_acc[d] = 1'b1;
            lat[d] = $urandom_range(0, 2);
          end
          if (lat[d] == 0) begin
            mem_complete(d);
            in_acc[d] = 1'b0;
          end else begin
            lat[d]--;
          end
        end
      end
      stray_ack = 1'b0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        if (data_ready0[d] && data_ready1[d]) fail_now("both_ready");
        for (int c = 0; c < 2; c++) begin
          if ((c == 0) ? data_ready0[d] : data_ready1[d]) begin
            if (exp_q[d*2+c].size() == 0) fail_now("spurious_ready");
            else check("pte_buf", pte_buf[d], exp_q[d*2+c].pop_front());
            if (order_q[d].size() == 0) fail_now("unexpected_service");
            else check("service_order", 32'(c), 32'(order_q[d].pop_front()));
          end
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic txn(input int d, input int c, input txn_t t);
    logic [31:0] a;
    int cnt;
    bit rdy;
    if (!t.act) return;
    a = ((c == 0) ? 32'h8000_1000 : 32'h8000_2000) + 32'(t.k * 4);
    mem_arr[d][c][t.k] = t.pte;
    err_rd[d][c] = t.er;
    err_wr[d][c] = t.ew;
    exp_addr[d][c] = a;
    exp_q[d*2+c].push_back(model_pte(d == 1, t.pte, t.er));
    repeat (t.dly) @(posedge clk);
    #1;
    if (c == 0) begin
      rd_req0[d] = 1'b1;
      pte_addr0[d] = a | {30'b0, t.lo};
    end else begin
      rd_req1[d] = 1'b1;
      pte_addr1[d] = a | {30'b0, t.lo};
    end
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      rdy = (c == 0) ? data_ready0[d] : data_ready1[d];
    end while (!rdy && cnt < 400);
    if (!rdy) fail_now("data_ready_timeout");
    // The walker keeps rd_req up one extra cycle after the pulse.
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (c == 0) rd_req0[d] = 1'b0;
    else rd_req1[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic step(input txn_t t0, input txn_t t1);
    int first;
    if (t0.act && t1.act) begin
      if (t0.dly < t1.dly) first = 0;
      else if (t1.dly < t0.dly) first = 1;
      else first = (last_served == 0) ? 1 : 0;
      for (int d = 0; d < 2; d++) begin
        order_q[d].push_back(first);
        order_q[d].push_back(1 - first);
      end
      last_served = 1 - first;
    end else if (t0.act || t1.act) begin
      for (int d = 0; d < 2; d++) order_q[d].push_back(t0.act ? 0 : 1);
      last_served = t0.act ? 0 : 1;
    end
    fork
      txn(0, 0, t0);
      txn(0, 1, t1);
      txn(1, 0, t0);
      txn(1, 1, t1);
    join
  endtask

  function automatic txn_t mk(input bit act, input logic [31:0] pte, input bit er, input bit ew,
                              input int dly, input int k, input logic [1:0] lo);
    txn_t t;
    t.act = act; t.pte = pte; t.er = er; t.ew = ew; t.dly = dly; t.k = k; t.lo = lo;
    return t;
  endfunction

  function automatic txn_t rand_txn(input bit act);
    logic [31:0] tbl [7];
    txn_t t;
    tbl = '{32'h2000_040F, 32'h0000_0C0B, 32'h0000_0C01, 32'h0000_0C4B,
            32'h0000_0C03, 32'h0000_0C09, 32'h0000_0C0A};
    t.act = act;
    t.pte = ($urandom_range(0, 3) == 0) ? $urandom : tbl[$urandom_range(0, 6)];
    t.er  = ($urandom_range(0, 9) == 0);
    t.ew  = ($urandom_range(0, 5) == 0);
    t.dly = $urandom_range(0, 3);
    t.k   = $urandom_range(0, 7);
    t.lo  = 2'($urandom_range(0, 3));
    return t;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    last_served = 1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    txn_t off;
    int   m;
    int   cnt;
    off = mk(1'b0, 32'h0, 1'b0, 1'b0, 0, 0, 2'b00);
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rd_req0[d] = 1'b0; rd_req1[d] = 1'b0;
      pte_addr0[d] = 32'h0; pte_addr1[d] = 32'h0;
      for (int c = 0; c < 2; c++) begin
        for (int k = 0; k < 8; k++) mem_arr[d][c][k] = 32'h0;
        err_rd[d][c] = 1'b0; err_wr[d][c] = 1'b0; exp_addr[d][c] = 32'h0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_mem_req", 32'(mem_req[d]), 32'd0);
      check("rst_mem_we", 32'(mem_we[d]), 32'd0);
      check("rst_mem_addr", mem_addr[d], 32'h0);
      check("rst_mem_wdata", mem_wdata[d], 32'h0);
      check("rst_pte_buf", pte_buf[d], 32'h0);
      check("rst_data_ready0", 32'(data_ready0[d]), 32'd0);
      check("rst_data_ready1", 32'(data_ready1[d]), 32'd0);
      check("rst_state", 32'(dbg_state[d]), 32'(ST_IDLE));
    end
    reset = 1'b0;
    last_served = 1;
    @(posedge clk); #1;

    // Plain read, A-bit update, non-leaf, A already set.
    step(mk(1'b1, 32'h2000_040F, 1'b0, 1'b0, 0, 1, 2'b00), off);
    step(mk(1'b1, 32'h0000_0C0B, 1'b0, 1'b0, 0, 3, 2'b01), off);
    step(mk(1'b1, 32'h0000_0C01, 1'b0, 1'b0, 1, 4, 2'b10), off);
    step(mk(1'b1, 32'h0000_0C4B, 1'b0, 1'b0, 0, 5, 2'b11), off);
    // Bus errors on the read and on the write-back.
    step(mk(1'b1, 32'h0000_0C0B, 1'b1, 1'b0, 0, 6, 2'b00), off);
    step(mk(1'b1, 32'h0000_0C0B, 1'b0, 1'b1, 0, 7, 2'b00), off);
    step(off, mk(1'b1, 32'h0000_0C03, 1'b0, 1'b0, 2, 2, 2'b11));

    // Simultaneous requests right after reset, twice.
    do_reset();
    step(mk(1'b1, 32'h0000_0C0B, 1'b0, 1'b0, 0, 0, 2'b00),
         mk(1'b1, 32'h0000_0C09, 1'b0, 1'b0, 0, 0, 2'b00));
    step(mk(1'b1, 32'h0000_0C01, 1'b0, 1'b0, 0, 1, 2'b00),
         mk(1'b1, 32'h0000_0C4B, 1'b0, 1'b0, 0, 1, 2'b00));

    for (int i = 0; i < 80; i++) begin
      m = $urandom_range(1, 3);
      step(rand_txn(m[0]), rand_txn(m[1]));
    end

    // Reset in the middle of a read, then a stray ack.
    hold_mem = 1'b1;
    for (int d = 0; d < 2; d++) begin
      mem_arr[d][0][2] = 32'h0000_0C0B;
      exp_addr[d][0] = 32'h8000_1008;
      rd_req0[d] = 1'b1;
      pte_addr0[d] = 32'h8000_1008;
    end
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!(mem_req[0] && mem_req[1]) && cnt < 50);
    if (!(mem_req[0] && mem_req[1])) fail_now("reset_test_mem_req_timeout");
    #1 reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("async_rst_mem_req", 32'(mem_req[d]), 32'd0);
      check("async_rst_state", 32'(dbg_state[d]), 32'(ST_IDLE));
    end
    @(posedge clk); #1;
    reset = 1'b0;
    hold_mem = 1'b0;
    for (int d = 0; d < 2; d++) rd_req0[d] = 1'b0;
    last_served = 1;
    @(negedge clk);
    stray_ack = 1'b1;
    repeat (4) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("stray_ack_state", 32'(dbg_state[d]), 32'(ST_IDLE));
      check("stray_ack_mem_req", 32'(mem_req[d]), 32'd0);
    end

    for (int i = 0; i < 4; i++) check("exp_q_drained", 32'(exp_q[i].size()), 32'd0);
    for (int d = 0; d < 2; d++) check("order_q_drained", 32'(order_q[d].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
